// File: rtl/coproc_host_if.sv
// Request/response and coprocessor word bus for the host-side initiator.
interface coproc_host_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [3:0]   req_sel;
  logic [255:0] req_wdata;
  logic         rsp_valid;
  logic [255:0] rsp_rdata;
  logic [31:0]  instruct;
  logic [31:0]  coproc_out;
  logic         busy;

  modport master (
    input  req_valid, req_write, req_sel, req_wdata, coproc_out,
    output req_ready, rsp_valid, rsp_rdata, instruct, busy
  );

  modport slave (
    output req_valid, req_write, req_sel, req_wdata, coproc_out,
    input  req_ready, rsp_valid, rsp_rdata, instruct, busy
  );
endinterface

// File: rtl/coproc_host_master.sv
// Host-side initiator: serialises one register request into a header word
// followed by data words (write) or result captures (read), and reassembles
// read words into a 256-bit response.
module coproc_host_master #(
  parameter int READ_LATENCY = 2,  // 1..7
  parameter int POST_GAP     = 2   // 1..7
) (
  input  logic          clock,
  input  logic          reset,
  coproc_host_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WDATA, S_RWAIT, S_RDATA, S_RSP, S_GAP
  } state_t;

  state_t             r_state, w_next;
  logic               r_write;
  logic [3:0]         r_sel;
  logic [2:0]         r_last;   // N-1, so N=8 is 7 rather than aliasing to 0
  logic [2:0]         r_cnt;
  logic [7:0][31:0]   r_wdata;
  logic [7:0][31:0]   r_rdata;
  logic [31:0]        w_instruct;
  logic               w_accept;

  // Index of the last word for each register: N(sel)-1.
  function automatic logic [2:0] last_idx(input logic [3:0] sel);
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9: last_idx = 3'd3;
      4'd5, 4'd6:                         last_idx = 3'd7;
      4'd12, 4'd13, 4'd14:                last_idx = 3'd4;
      default:                            last_idx = 3'd0;
    endcase
  endfunction

  assign w_accept = bus.req_valid && (r_state == S_IDLE) && !reset;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and word-bus output decode.
  always_comb begin
    w_next     = r_state;
    w_instruct = '0;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_HDR;
      S_HDR: begin
        w_instruct = {r_write, 27'b0, r_sel};
        if (r_write)                w_next = S_WDATA;
        else if (READ_LATENCY == 1) w_next = S_RDATA;
        else                        w_next = S_RWAIT;
      end
      S_WDATA: begin
        w_instruct = r_wdata[r_cnt];
        if (r_cnt == r_last) w_next = S_GAP;
      end
      // Waits READ_LATENCY-1 cycles so the first capture lands at H+READ_LATENCY.
      S_RWAIT: if (r_cnt == 3'(READ_LATENCY - 2)) w_next = S_RDATA;
      S_RDATA: if (r_cnt == r_last) w_next = S_RSP;
      S_RSP:   w_next = S_GAP;
      S_GAP:   if (r_cnt == 3'(POST_GAP - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared phase counter: restarts on every state change, holds while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (r_state != S_IDLE) r_cnt <= r_cnt + 3'd1;
  end

  // Request latch and read-word reassembly; unused read words stay cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_sel   <= '0;
      r_last  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_sel   <= bus.req_sel;
      r_last  <= last_idx(bus.req_sel);
      r_wdata <= bus.req_wdata;
      if (!bus.req_write) r_rdata <= '0;
    end else if (r_state == S_RDATA) begin
      r_rdata[r_cnt] <= bus.coproc_out;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE) && !reset;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.instruct  = w_instruct;

endmodule

// File: tb/tb_coproc_host_master.sv
// Self-checking bench for coproc_host_master: table-driven register
// requests, directed corner sequences and randomized traffic, all compared
// cycle by cycle against a transaction-level model.
module tb_coproc_host_master;
  localparam int RL = 2;
  localparam int PG = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  coproc_host_if bus();

  coproc_host_master #(.READ_LATENCY(RL), .POST_GAP(PG)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [255:0] last_rdata = '0;

  typedef struct {
    bit         wr;
    logic [3:0] sel;
    int         n;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic int n_of(input logic [3:0] sel);
    case (sel)
      0, 1, 2, 4, 8, 9: return 4;
      5, 6:             return 8;
      12, 13, 14:       return 5;
      default:          return 1;
    endcase
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Called at a falling edge with the DUT idle. Model: header at H, write
  // words at H+1..H+n, read captures at H+RL..H+RL+n-1, response pulse at
  // H+RL+n, then PG idle cycles, then ready again.
  task automatic run_txn(input bit wr, input logic [3:0] sel, input int n,
                         input logic [255:0] wdata, input logic [255:0] rwords,
                         input bit keep);
    int len;
    logic [31:0]  exp_i;
    logic [255:0] one, mask;
    len  = wr ? (1 + n + PG) : (RL + n + 1 + PG);
    one  = 256'd1;
    mask = (one << (32 * n)) - one;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_sel   = sel;
    bus.req_wdata = wdata;
    @(posedge clock);
    @(negedge clock);
    for (int t = 0; t < len; t++) begin
      if (t == 0)                      exp_i = {wr, 27'b0, sel};
      else if (wr && t <= n)           exp_i = wdata[32*(t-1) +: 32];
      else                             exp_i = 32'h0;
      chk("instruct", bus.instruct, exp_i);
      chk("rsp_valid", bus.rsp_valid, (!wr && t == RL + n));
      chk("ready_busy", bus.req_ready, 1'b0);
      chk("busy", bus.busy, 1'b1);
      bus.coproc_out = (!wr && t >= RL && t < RL + n) ? rwords[32*(t-RL) +: 32] : $urandom;
      if (keep) begin
        bus.req_write = $urandom_range(0, 1);
        bus.req_sel   = 4'($urandom_range(0, 15));
        bus.req_wdata = rnd256();
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clock);
    end
    chk("ready_after", bus.req_ready, 1'b1);
    chk("busy_after", bus.busy, 1'b0);
    chk("instruct_idle", bus.instruct, 32'h0);
    if (!wr) last_rdata = rwords & mask;
    chk(wr ? "rdata_kept" : "rdata", bus.rsp_rdata, last_rdata);
  endtask

  vec_t vecs[20];

  initial begin
    logic [255:0] wd, rw;
    vecs[0]  = '{0, 4'd0, 4};  vecs[1]  = '{0, 4'd1, 4};  vecs[2]  = '{0, 4'd2, 4};
    vecs[3]  = '{0, 4'd3, 1};  vecs[4]  = '{0, 4'd4, 4};  vecs[5]  = '{0, 4'd5, 8};
    vecs[6]  = '{0, 4'd6, 8};  vecs[7]  = '{0, 4'd7, 1};  vecs[8]  = '{0, 4'd8, 4};
    vecs[9]  = '{0, 4'd9, 4};  vecs[10] = '{0, 4'd10, 1}; vecs[11] = '{0, 4'd11, 1};
    vecs[12] = '{0, 4'd12, 5}; vecs[13] = '{0, 4'd13, 5}; vecs[14] = '{0, 4'd14, 5};
    vecs[15] = '{0, 4'd15, 1}; vecs[16] = '{1, 4'd6, 8};  vecs[17] = '{1, 4'd12, 5};
    vecs[18] = '{1, 4'd15, 1}; vecs[19] = '{1, 4'd9, 4};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_sel    = '0;
    bus.req_wdata  = '0;
    bus.coproc_out = '0;

    // Reset state
    #12;
    chk("rst_instruct", bus.instruct, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rdata", bus.rsp_rdata, 256'h0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", bus.req_ready, 1'b1);

    // Write sel=4 with the documented payload
    wd = '0;
    wd[31:0] = 32'h11111111; wd[63:32] = 32'h22222222;
    wd[95:64] = 32'h33333333; wd[127:96] = 32'h44444444;
    wd[159:128] = 32'h55555555;
    run_txn(1'b1, 4'd4, 4, wd, '0, 1'b0);

    // Read sel=5, words 0xA0..0xA7
    rw = '0;
    for (int i = 0; i < 8; i++) rw[32*i +: 32] = 32'hA0 + i;
    run_txn(1'b0, 4'd5, 8, '0, rw, 1'b0);

    // Read sel=3, single word; upper bits must come back zero
    rw = rnd256();
    rw[31:0] = 32'hDEADBEEF;
    run_txn(1'b0, 4'd3, 1, '0, rw, 1'b0);

    // Write sel=13: five words, word 5 must never appear
    wd = rnd256();
    wd[191:160] = 32'hBADBAD55;
    run_txn(1'b1, 4'd13, 5, wd, '0, 1'b0);

    // Table of register requests
    for (int v = 0; v < 20; v++)
      run_txn(vecs[v].wr, vecs[v].sel, vecs[v].n, rnd256(), rnd256(), 1'b0);

    // Reset asserted while write word 2 of sel=0 is on the bus
    wd = rnd256();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_sel = 4'd0; bus.req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("abort_hdr", bus.instruct, 32'h80000000);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("abort_word2", bus.instruct, wd[95:64]);
    #1 reset = 1'b1;
    #1;
    chk("abort_instruct", bus.instruct, 32'h0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort_rdata", bus.rsp_rdata, 256'h0);
    last_rdata = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready", bus.req_ready, 1'b1);
    chk("abort_no_rsp", bus.rsp_valid, 1'b0);
    run_txn(1'b0, 4'd0, 4, '0, rnd256(), 1'b0);

    // req_valid held high: alternating write/read sel=8, back to back
    for (int k = 0; k < 4; k++)
      run_txn((k % 2) == 0, 4'd8, 4, rnd256(), rnd256(), 1'b1);
    bus.req_valid = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      logic [3:0] s;
      s = 4'($urandom_range(0, 15));
      run_txn($urandom_range(0, 1), s, n_of(s), rnd256(), rnd256(), $urandom_range(0, 1));
    end
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("final_idle", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coproc_host_master.md
Name: coproc_host_master

Overview:
- Host-side initiator for the coprocessor's 32-bit instruction port; drives `instruct` and collects results from `out`.
- Accepts one register-level request per handshake and serialises it: a header word, then 32-bit data words for a write, or 32-bit result captures for a read.
- Reassembles read words into a 256-bit response.
- Lets the rest of the design (test harness, SoC bus bridge) access the datapath registers without knowing the word-level protocol.

Parameters:
- READ_LATENCY, 2: cycles from header drive (cycle H) to capture of read word 0 from `out`; legal range 1..7.
- POST_GAP, 2: idle cycles (`instruct`=0) driven after every transaction before `req_ready` reasserts; legal range 1..7.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and able to accept a request.
- req_write  input  1  1 = register write, 0 = register read.
- req_sel  input  4  target register index.
- req_wdata  input  256  write payload; word i is bits [32i+31:32i].
- rsp_valid  output  1  one-cycle pulse; `rsp_rdata` is valid.
- rsp_rdata  output  256  read result; word i in bits [32i+31:32i].
- instruct  output  32  instruction/data word to the coprocessor.
- coproc_out  input  32  result word from the coprocessor.
- busy  output  1  high from acceptance until return to IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; `instruct`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0; counters cleared; `req_ready`=1 once reset deasserts.
- Reset mid-transaction: the transaction is aborted, no `rsp_valid` is produced, and all outputs take their reset values.
- Word count N(sel):
  - sel 0,1,2,4,8,9 → 4
  - sel 5,6 → 8
  - sel 12,13,14 → 5
  - all other sel → 1
- Handshake:
  - `req_ready` = (state==IDLE).
  - Acceptance when `req_valid` && `req_ready`; `req_write`, `req_sel`, `req_wdata` and N are latched.
  - Inputs are ignored while not IDLE.
- States:
  - IDLE: `instruct`=0. On acceptance, go to HDR.
  - HDR (one cycle, cycle H): `instruct` = {`req_write`, 27'b0, `req_sel`}, so bit31=1 is write and bit31=0 is read. Next state is WDATA if write, RWAIT if read.
  - WDATA: for k=0..N-1, `instruct` = word k of the latched payload in cycle H+1+k. Go to GAP after word N-1.
  - RWAIT: `instruct`=0. Counts until cycle H+READ_LATENCY, then goes to RDATA.
  - RDATA: for i=0..N-1, in cycle H+READ_LATENCY+i, `coproc_out` is captured into `rsp_rdata` word i. Words N..7 are forced to 0. `instruct`=0. In the cycle after the last capture, `rsp_valid`=1 for exactly one cycle, then go to GAP.
  - GAP: `instruct`=0 for POST_GAP cycles, then go to IDLE.
- Write transactions never assert `rsp_valid`.
- `rsp_rdata`:
  - Cleared to 0 at the start of each read (entry to HDR for a read).
  - Holds its value after `rsp_valid` until the next read's HDR.
  - Unchanged by writes.
- Back-to-back requests: the earliest next HDR is the cycle after the last GAP cycle plus one IDLE acceptance cycle.
- Counters wrap-free: the word counter is 3 bits plus a done flag; N=8 must not alias to 0.

Test Plan:
- Write sel=4, wdata words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 → `instruct` sequence 0x80000004, 0x11111111, 0x22222222, 0x33333333, 0x44444444, then 0 for 2 cycles; `req_ready` back after GAP; `rsp_valid` never high.
- Read sel=5, READ_LATENCY=2, bench drives `coproc_out`=0xA0+i in cycles H+2+i, i=0..7 → `instruct`=0x00000005 then 0; `rsp_rdata` words 0..7 = 0xA0..0xA7; one `rsp_valid` pulse at cycle H+10.
- Read sel=3 (N=1), `coproc_out`=0xDEADBEEF at H+2 → `rsp_rdata`[31:0]=0xDEADBEEF, bits [255:32]=0; `rsp_valid` at H+3.
- Write sel=13 (N=5) → exactly 5 data words follow header 0x8000000D; word 5 of `req_wdata` is never driven.
- Reset asserted during WDATA word 2 of a sel=0 write → `instruct`=0 immediately (asynchronous); `req_ready`=1 after release; a subsequent read sel=0 completes normally.
- `req_valid` held high continuously with alternating write/read sel=8 → each request is accepted only in IDLE, with no overlap of HDR/data phases and the POST_GAP spacing respected.
